ahb_master_busreq: RTL and testbench

- Master-side bus-request/grant controller for the AHB arbiter: the requesting end of the HBUSREQ/HGRANT handshake that the arbiter's priority logic resolves.
- Accepts a transfer command (beat count, lock), raises HBUSREQ/HLOCK, tracks address-bus ownership from HGRANT/HREADY and sequences address and data beats.
- On grant loss mid-burst, re-arbitrates for the remaining beats.
- Sits between a master's command source and its HTRANS/HADDR drivers.

---
 rtl/ahb_master_busreq_pkg.sv | 31 +++
 rtl/ahb_master_busreq.sv | 182 ++++++++++++++++++
 tb/tb_ahb_master_busreq.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_master_busreq_pkg.sv
// rtl/ahb_master_busreq_pkg.sv - shared AHB encodings for the master bus-request controller
//
// Purpose: state encoding of the request/grant sequencer plus the HTRANS and
// HBURST codes the downstream address driver uses alongside first_beat.
// Ports: none (package).

package ahb_master_busreq_pkg;

  // Sequencer states:
  //   ST_IDLE - waiting for a command
  //   ST_REQ  - requesting the bus
  //   ST_ADDR - owning the address bus
  //   ST_DATA - waiting for the final data phase
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_ADDR = 2'b10,
    ST_DATA = 2'b11
  } busreq_state_t;

  // HTRANS encodings driven by the address-phase driver.
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Undefined-length incrementing burst. Every (re)grant restarts with
  // NONSEQ/INCR, so the beat count never has to match a fixed burst type.
  localparam logic [2:0] HBURST_INCR   = 3'b001;

endpackage

// File: rtl/ahb_master_busreq.sv
// rtl/ahb_master_busreq.sv - AHB master bus-request/grant controller
//
// Purpose: accepts a transfer command (beat count, lock), requests the bus,
// tracks address-bus ownership from HGRANT/HREADY, sequences address beats and
// re-arbitrates for the remaining beats when the grant is lost mid-burst.
//
// Ports:
//   HCLK        in   bus clock, rising edge
//   HRESET      in   synchronous active-high reset
//   cmd_valid   in   command request
//   cmd_ready   out  command accepted when cmd_valid & cmd_ready
//   cmd_beats   in   beat count (0 means 1)
//   cmd_lock    in   locked transfer request
//   HGRANT      in   grant from arbiter
//   HREADY      in   bus ready
//   HBUSREQ     out  bus request to arbiter
//   HLOCK       out  lock request to arbiter
//   addr_phase  out  valid address/control phase driven this cycle
//   first_beat  out  first address phase after a (re)grant (NONSEQ/INCR)
//   beat_idx    out  0-based beat index of the current address phase
//   data_phase  out  this master owns the current data phase
//   done        out  one-cycle pulse after the final data phase completes

module ahb_master_busreq
  import ahb_master_busreq_pkg::*;
#(
  parameter int BEATW = 5
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [BEATW-1:0] cmd_beats,
  input  logic             cmd_lock,
  input  logic             HGRANT,
  input  logic             HREADY,
  output logic             HBUSREQ,
  output logic             HLOCK,
  output logic             addr_phase,
  output logic             first_beat,
  output logic [BEATW-1:0] beat_idx,
  output logic             data_phase,
  output logic             done
);

  localparam logic [BEATW-1:0] LP_ONE = {{(BEATW-1){1'b0}}, 1'b1};

  busreq_state_t    r_state;
  busreq_state_t    w_state_nxt;

  logic [BEATW-1:0] r_remaining;
  logic [BEATW-1:0] r_beat_idx;
  logic             r_lock;
  logic             r_first;
  logic             r_data_phase;
  logic             r_done;

  logic [BEATW-1:0] w_beats_norm;
  logic             w_accept;
  logic             w_beat_acc;
  logic             w_last_beat;
  logic             w_data_done;

  assign w_beats_norm = (cmd_beats == '0) ? LP_ONE : cmd_beats;
  assign w_last_beat  = (r_remaining == LP_ONE);
  assign w_accept     = (r_state == ST_IDLE) && cmd_valid;
  // An address beat is taken by the slave on any HREADY edge while we own
  // the address bus; HGRANT only matters for what happens afterwards.
  assign w_beat_acc   = (r_state == ST_ADDR) && HREADY;
  assign w_data_done  = (r_state == ST_DATA) && r_data_phase && HREADY;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and bus-facing outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    HBUSREQ     = 1'b0;
    HLOCK       = 1'b0;
    addr_phase  = 1'b0;
    first_beat  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_state_nxt = ST_REQ;
        end
      end

      ST_REQ: begin
        HBUSREQ = 1'b1;
        HLOCK   = r_lock;
        // Ownership moves only on an HREADY edge; a grant seen while the
        // bus is stalled is not ours yet.
        if (HGRANT && HREADY) begin
          w_state_nxt = ST_ADDR;
        end
      end

      ST_ADDR: begin
        addr_phase = 1'b1;
        first_beat = r_first;
        HLOCK      = r_lock;
        // Drop the request during the final address beat so the arbiter
        // can hand the bus on without a wasted cycle.
        HBUSREQ    = !w_last_beat;
        if (HREADY) begin
          if (w_last_beat) begin
            w_state_nxt = ST_DATA;
          end else if (!HGRANT) begin
            w_state_nxt = ST_REQ;
          end
        end
      end

      ST_DATA: begin
        if (r_data_phase && HREADY) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch and beat counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_remaining <= '0;
      r_beat_idx  <= '0;
      r_lock      <= 1'b0;
      r_first     <= 1'b0;
    end else if (w_accept) begin
      r_remaining <= w_beats_norm;
      r_beat_idx  <= '0;
      r_lock      <= cmd_lock;
      r_first     <= 1'b1;
    end else if (w_beat_acc) begin
      r_remaining <= r_remaining - LP_ONE;
      r_beat_idx  <= r_beat_idx + LP_ONE;
      // Losing the grant with beats still to go means the next address
      // phase starts a fresh NONSEQ after re-arbitration.
      r_first     <= !w_last_beat && !HGRANT;
    end
  end

  // ---------------------------------------------------------------------------
  // Data-phase ownership and completion pulse
  // Kept independent of the FSM so a data phase left behind by a grant loss
  // still completes while the FSM is back in ST_REQ.
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_data_phase <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_data_phase <= w_beat_acc || (r_data_phase && !HREADY);
      r_done       <= w_data_done;
    end
  end

  assign beat_idx   = r_beat_idx;
  assign data_phase = r_data_phase;
  assign done       = r_done;

endmodule

// File: tb/tb_ahb_master_busreq.sv
// tb/tb_ahb_master_busreq.sv - self-checking bench for ahb_master_busreq

module tb_ahb_master_busreq;

  localparam int BEATW = 5;

  logic             HCLK = 1'b0;
  logic             HRESET;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [BEATW-1:0] cmd_beats;
  logic             cmd_lock;
  logic             HGRANT;
  logic             HREADY;
  logic             HBUSREQ;
  logic             HLOCK;
  logic             addr_phase;
  logic             first_beat;
  logic [BEATW-1:0] beat_idx;
  logic             data_phase;
  logic             done;

  always #5 HCLK = ~HCLK;

  ahb_master_busreq #(.BEATW(BEATW)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_beats  (cmd_beats),
    .cmd_lock   (cmd_lock),
    .HGRANT     (HGRANT),
    .HREADY     (HREADY),
    .HBUSREQ    (HBUSREQ),
    .HLOCK      (HLOCK),
    .addr_phase (addr_phase),
    .first_beat (first_beat),
    .beat_idx   (beat_idx),
    .data_phase (data_phase),
    .done       (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level reference: a queue of beat indices still to be issued,
  // whether we hold the address bus, and whether the final data phase is in
  // flight.
  bit m_valid     = 1'b0;
  bit m_active    = 1'b0;
  int m_q[$];
  bit m_lock      = 1'b0;
  bit m_owner     = 1'b0;
  bit m_first     = 1'b0;
  bit m_dphase    = 1'b0;
  bit m_last_pend = 1'b0;
  bit m_done      = 1'b0;

  // Observations from the most recent step.
  logic             o_ready, o_req, o_lock, o_addr, o_first, o_dph, o_done;
  logic [BEATW-1:0] o_idx;
  logic [BEATW-1:0] obs_idx[$];
  bit               obs_first[$];
  bit               obs_req[$];
  int               obs_dones;

  typedef struct {
    bit v;
    int beats;
    bit lk;
    bit g;
    bit r;
    bit e_ready;
    bit e_req;
    bit e_lock;
    bit e_addr;
    bit e_first;
    bit e_dph;
    bit e_done;
    int e_idx;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit v, input int beats, input bit lk,
                            input bit g, input bit r);
    bit old_active;
    bit b;
    bit nd;
    int n;
    if (rst) begin
      m_valid = 1'b1; m_active = 1'b0; m_q.delete(); m_lock = 1'b0; m_owner = 1'b0;
      m_first = 1'b0; m_dphase = 1'b0; m_last_pend = 1'b0; m_done = 1'b0;
      return;
    end
    old_active = m_active;
    b  = m_owner && r;
    nd = r && m_dphase && m_last_pend;
    m_dphase = b ? 1'b1 : (r ? 1'b0 : m_dphase);
    m_done   = nd;
    if (nd) begin
      m_active    = 1'b0;
      m_last_pend = 1'b0;
    end
    if (b) begin
      void'(m_q.pop_front());
      m_first = 1'b0;
      if (m_q.size() == 0) begin
        m_owner     = 1'b0;
        m_last_pend = 1'b1;
      end else if (!g) begin
        m_owner = 1'b0;
        m_first = 1'b1;
      end
    end else if (old_active && m_q.size() > 0 && !m_owner && g && r) begin
      m_owner = 1'b1;
    end
    if (!old_active && v) begin
      n = (beats % 32 == 0) ? 1 : beats % 32;
      m_active = 1'b1;
      m_q.delete();
      for (int i = 0; i < n; i++) m_q.push_back(i);
      m_lock  = lk;
      m_first = 1'b1;
      m_owner = 1'b0;
    end
  endtask

  task automatic step(input bit rst, input bit v, input int beats, input bit lk,
                      input bit g, input bit r);
    logic [11:0] act;
    logic [11:0] exp;
    bit          e_req, e_lock;
    logic [BEATW-1:0] e_idx;
    HRESET    = rst;
    cmd_valid = v;
    cmd_beats = beats[BEATW-1:0];
    cmd_lock  = lk;
    HGRANT    = g;
    HREADY    = r;
    @(negedge HCLK);
    o_ready = cmd_ready; o_req = HBUSREQ; o_lock = HLOCK; o_addr = addr_phase;
    o_first = first_beat; o_dph = data_phase; o_done = done; o_idx = beat_idx;
    if (o_addr === 1'b1) begin
      obs_idx.push_back(o_idx);
      obs_first.push_back(o_first);
      obs_req.push_back(o_req);
    end
    if (o_done === 1'b1) obs_dones++;
    if (m_valid) begin
      e_req  = m_active && m_q.size() > 0 && !(m_owner && m_q.size() == 1);
      e_lock = m_active && m_q.size() > 0 && m_lock;
      e_idx  = m_owner ? BEATW'(m_q[0]) : '0;
      exp = {!m_active, e_req, e_lock, m_owner, m_owner && m_first, m_dphase, m_done, e_idx};
      act = {o_ready, o_req, o_lock, o_addr, o_first, o_dph, o_done,
             (o_addr === 1'b1) ? o_idx : ((o_addr === 1'b0) ? '0 : 'x)};
      chk("model", {20'd0, act}, {20'd0, exp});
    end
    model_edge(rst, v, beats, lk, g, r);
    @(posedge HCLK);
    #1;
  endtask

  task automatic clear_obs();
    obs_idx.delete();
    obs_first.delete();
    obs_req.delete();
    obs_dones = 0;
  endtask

  initial begin
    logic [11:0] act;
    logic [11:0] exp;
    int          accepts;

    // ---------------- reset ----------------
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("reset_outs", {25'd0, o_ready, o_req, o_lock, o_addr, o_first, o_dph, o_done},
        {25'd0, 7'b1000000});
    chk("reset_idx", {27'd0, o_idx}, 32'd0);

    // ---------------- table: single beat, then beats=0 locked ----------------
    tv[0]  = '{1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    tv[3]  = '{0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    tv[4]  = '{0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    tv[5]  = '{0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[6]  = '{1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[7]  = '{0, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0};
    tv[8]  = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
    tv[9]  = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    tv[10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    tv[11] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      step(0, tv[i].v, tv[i].beats, tv[i].lk, tv[i].g, tv[i].r);
      exp = {tv[i].e_ready, tv[i].e_req, tv[i].e_lock, tv[i].e_addr, tv[i].e_first,
             tv[i].e_dph, tv[i].e_done, tv[i].e_addr ? BEATW'(tv[i].e_idx) : 5'd0};
      act = {o_ready, o_req, o_lock, o_addr, o_first, o_dph, o_done,
             (o_addr === 1'b1) ? o_idx : ((o_addr === 1'b0) ? 5'd0 : 5'bx)};
      chk($sformatf("table_row%0d", i), {20'd0, act}, {20'd0, exp});
    end

    // ---------------- HREADY stall during beat 2 ----------------
    clear_obs();
    step(0, 1, 4, 0, 1, 1);
    step(0, 0, 4, 0, 1, 1);
    step(0, 0, 4, 0, 1, 1);
    step(0, 0, 4, 0, 1, 1);
    step(0, 0, 4, 0, 1, 0);
    step(0, 0, 4, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 4, 0, 1, 1);
    chk("stall_n_addr", obs_idx.size(), 6);
    if (obs_idx.size() == 6) begin
      chk("stall_idx_seq", {obs_idx[0], obs_idx[1], obs_idx[2], obs_idx[3], obs_idx[4], obs_idx[5]},
          {5'd0, 5'd1, 5'd2, 5'd2, 5'd2, 5'd3});
      chk("stall_first", {obs_first[0], obs_first[1], obs_first[2], obs_first[3], obs_first[4], obs_first[5]},
          6'b100000);
      chk("stall_busreq", {obs_req[4], obs_req[5]}, 2'b10);
    end
    chk("stall_dones", obs_dones, 1);

    // ---------------- grant lost at the edge accepting beat 1 ----------------
    clear_obs();
    step(0, 1, 4, 0, 1, 1);
    step(0, 0, 4, 0, 1, 1);
    step(0, 0, 4, 0, 1, 1);
    step(0, 0, 4, 0, 0, 1);
    step(0, 0, 4, 0, 0, 1);
    chk("regrant_req_state", {o_addr, o_req, o_dph}, 3'b011);
    for (int i = 0; i < 6; i++) step(0, 0, 4, 0, 1, 1);
    chk("regrant_n_addr", obs_idx.size(), 4);
    if (obs_idx.size() == 4) begin
      chk("regrant_idx_seq", {obs_idx[0], obs_idx[1], obs_idx[2], obs_idx[3]},
          {5'd0, 5'd1, 5'd2, 5'd3});
      chk("regrant_first", {obs_first[0], obs_first[1], obs_first[2], obs_first[3]}, 4'b1010);
    end
    chk("regrant_dones", obs_dones, 1);

    // ---------------- reset in ADDR at beat_idx 2 ----------------
    clear_obs();
    step(0, 1, 4, 0, 1, 1);
    step(0, 0, 4, 0, 1, 1);
    step(0, 0, 4, 0, 1, 1);
    step(0, 0, 4, 0, 1, 1);
    step(1, 0, 4, 0, 1, 1);
    chk("rst_mid_at_idx", {27'd0, o_idx}, 32'd2);
    step(0, 0, 2, 0, 1, 1);
    chk("rst_mid_outs", {o_ready, o_req, o_lock, o_addr, o_first, o_dph, o_done}, 7'b1000000);
    chk("rst_mid_idx", {27'd0, o_idx}, 32'd0);
    clear_obs();
    step(0, 1, 2, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 2, 0, 1, 1);
    chk("rst_new_dones", obs_dones, 1);
    chk("rst_new_n_addr", obs_idx.size(), 2);

    // ---------------- back-to-back with cmd_valid held ----------------
    clear_obs();
    step(0, 1, 3, 0, 1, 1);
    for (int i = 0; i < 40 && obs_dones < 2; i++) begin
      step(0, 1, 2, 0, 1, 1);
      if (o_done === 1'b1) chk("b2b_ready_at_done", o_ready, 1'b1);
    end
    chk("b2b_dones", obs_dones, 2);
    chk("b2b_n_addr", obs_idx.size(), 5);
    if (obs_idx.size() == 5) begin
      chk("b2b_idx_seq", {obs_idx[0], obs_idx[1], obs_idx[2], obs_idx[3], obs_idx[4]},
          {5'd0, 5'd1, 5'd2, 5'd0, 5'd1});
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 1);

    // ---------------- randomized traffic against the model ----------------
    accepts = 0;
    clear_obs();
    for (int i = 0; i < 4000; i++) begin
      bit rst, v, lk, g, r;
      int beats;
      rst   = ($urandom_range(0, 599) == 0);
      v     = ($urandom_range(0, 3) == 0);
      lk    = $urandom_range(0, 1);
      g     = ($urandom_range(0, 3) != 0);
      r     = ($urandom_range(0, 4) != 0);
      beats = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
      if (!rst && v && !m_active) accepts++;
      step(rst, v, beats, lk, g, r);
    end
    chk("rand_some_accepts", accepts > 20, 1'b1);
    chk("rand_some_dones", obs_dones > 10, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
